demux1_4_sched: RTL and testbench

//  Dispatch controller for the 1:4 demux datapath. Accepts words from one source over a

---
 rtl/demux_sched_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/demux1_4_sched.sv | 122 ++++++++++++
 tb/tb_demux1_4_sched.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1:4 demux dispatch controller.
//   state_e       : holding-register occupancy (EMPTY / FULL)
//   CH_A..CH_D    : channel indices, also the s1/s2 select encoding
//   DEF_DW/CNT_W  : default data and statistics-counter widths
package demux_sched_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   localparam int unsigned DEF_DW    = 8;
   localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker over four channels.
//   mask : channel enables, bit0 = a ... bit3 = d
//   ptr  : highest-priority channel this cycle
//   idx  : first enabled channel at or after ptr, wrapping 3 -> 0
//   any  : at least one channel enabled (idx valid only when set)
module rr_pick4
   import demux_sched_pkg::*;
(
   input  logic [3:0] mask,
   input  logic [1:0] ptr,
   output logic [1:0] idx,
   output logic       any
);

   logic [1:0] cand;

   always_comb begin
      idx  = CH_A;
      any  = 1'b0;
      cand = ptr;
      for (int unsigned i = 0; i < 4; i++) begin
         // 2-bit add wraps naturally, giving the rotated search order
         cand = ptr + 2'(i);
         if (!any && mask[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux1_4_sched.sv
// Dispatch controller for the 1:4 demux datapath. Accepts words over a
// valid/ready handshake, routes each to sink a..d (fixed or round-robin),
// and holds it in a one-entry register until that sink accepts it.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : source handshake; in_data, in_dest source word/dest
//   rr_mode, chan_en     : routing mode and per-channel enables
//   s1, s2               : demux selects = registered dest of held word
//   out_valid/out_ready  : one-hot sink handshake; out_data held word
//   disp_cnt, drop_cnt   : saturating delivered / dropped word counts
module demux1_4_sched
   import demux_sched_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic [1:0]       in_dest,
   input  logic             rr_mode,
   input  logic [3:0]       chan_en,
   output logic             s1,
   output logic             s2,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [DW-1:0]    out_data,
   output logic [CNT_W-1:0] disp_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   state_e           state_q, state_d;
   logic [DW-1:0]    data_q, data_d;
   logic [1:0]       dest_q, dest_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] disp_cnt_q, disp_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [1:0] rr_idx;
   logic       rr_any;
   logic       route_ok;
   logic       delivery;
   logic       transfer;
   logic       store;
   logic       drop;

   rr_pick4 u_pick (
      .mask (chan_en),
      .ptr  (rr_ptr_q),
      .idx  (rr_idx),
      .any  (rr_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         data_q     <= '0;
         dest_q     <= CH_A;
         rr_ptr_q   <= CH_A;
         disp_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         dest_q     <= dest_d;
         rr_ptr_q   <= rr_ptr_d;
         disp_cnt_q <= disp_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      dest_d     = dest_q;
      rr_ptr_d   = rr_ptr_q;
      disp_cnt_d = disp_cnt_q;
      drop_cnt_d = drop_cnt_q;

      out_valid = '0;
      if (state_q == FULL) begin
         out_valid = 4'b0001 << dest_q;
      end

      route_ok = rr_mode ? rr_any : 1'b1;
      delivery = (state_q == FULL) && out_ready[dest_q];
      in_ready = ((state_q == EMPTY) || delivery) && route_ok;
      transfer = in_valid && in_ready;

      // A fixed-mode word to a disabled channel is consumed but never stored,
      // so the holding register's occupancy follows only delivery that cycle.
      store = transfer && (rr_mode || chan_en[in_dest]);
      drop  = transfer && !rr_mode && !chan_en[in_dest];

      if (store) begin
         state_d = FULL;
         data_d  = in_data;
         dest_d  = rr_mode ? rr_idx : in_dest;
      end else if (delivery) begin
         state_d = EMPTY;
      end

      if (transfer && rr_mode) begin
         rr_ptr_d = rr_idx + 2'd1;
      end

      if (delivery && (disp_cnt_q != '1)) begin
         disp_cnt_d = disp_cnt_q + CNT_W'(1);
      end
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   assign s1       = dest_q[1];
   assign s2       = dest_q[0];
   assign out_data = data_q;
   assign disp_cnt = disp_cnt_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux1_4_sched.sv
module tb_demux1_4_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_dest;
   logic        rr_mode;
   logic [3:0]  chan_en;
   logic        s1, s2;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [7:0]  out_data;
   logic [15:0] disp_cnt;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux1_4_sched #(.DW(8), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .rr_mode   (rr_mode),
      .chan_en   (chan_en),
      .s1        (s1),
      .s2        (s2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .disp_cnt  (disp_cnt),
      .drop_cnt  (drop_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0;
      rr_mode = 1'b0; chan_en = 4'hF; out_ready = 4'hF;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got %b exp 0000", out_valid); end
      checks++; if ({s1, s2} !== 2'b00) begin errors++; $display("FAIL rst_sel got %b exp 00", {s1, s2}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      checks++; if (disp_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", disp_cnt, drop_cnt); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", out_data); end
   endtask

   task automatic test_fixed();
      in_valid = 1'b1; in_dest = 2'd2; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL fix_out_valid got %b exp 0100", out_valid); end
      checks++; if ({s1, s2} !== 2'b10) begin errors++; $display("FAIL fix_sel got %b exp 10", {s1, s2}); end
      checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL fix_out_data got %h exp a5", out_data); end
      tick();
      checks++; if (disp_cnt !== 16'd1) begin errors++; $display("FAIL fix_disp_cnt got %0d exp 1", disp_cnt); end
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL fix_empty got %b exp 0000", out_valid); end
      checks++; if ({s1, s2} !== 2'b10) begin errors++; $display("FAIL fix_sel_hold got %b exp 10", {s1, s2}); end
   endtask

   task automatic test_rr();
      logic [3:0] exp_v [4];
      exp_v[0] = 4'b0001; exp_v[1] = 4'b0010; exp_v[2] = 4'b1000; exp_v[3] = 4'b0001;
      rr_mode = 1'b1; chan_en = 4'b0000;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rr_none_ready got %b exp 0", in_ready); end
      chan_en = 4'b1011; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'h10 + 8'(i);
         tick();
         checks++;
         if (out_valid !== exp_v[i] || out_data !== 8'h10 + 8'(i)) begin
            errors++;
            $display("FAIL rr_word%0d got %b/%h exp %b/%h", i, out_valid, out_data, exp_v[i], 8'h10 + 8'(i));
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (disp_cnt !== 16'd5) begin errors++; $display("FAIL rr_disp_cnt got %0d exp 5", disp_cnt); end
      // pointer now at b after the last pick of a
      in_valid = 1'b1; in_data = 8'h55;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL rr_ptr_next got %b exp 0010", out_valid); end
      tick();
      rr_mode = 1'b0; chan_en = 4'hF;
   endtask

   task automatic test_back_to_back();
      out_ready = 4'b1101;
      in_valid = 1'b1; in_dest = 2'd1; in_data = 8'h3C;
      tick();
      in_dest = 2'd0; in_data = 8'h77;
      for (int i = 0; i < 5; i++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b exp 0", i, in_ready); end
         tick();
         checks++;
         if (out_data !== 8'h3C || out_valid !== 4'b0010) begin
            errors++;
            $display("FAIL bp_hold%0d got %h/%b exp 3c/0010", i, out_data, out_valid);
         end
      end
      out_ready = 4'hF;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_data !== 8'h77 || out_valid !== 4'b0001) begin errors++; $display("FAIL bp_next got %h/%b exp 77/0001", out_data, out_valid); end
      tick();
      checks++; if (disp_cnt !== 16'd8 || out_valid !== 4'b0000) begin errors++; $display("FAIL bp_disp got %0d/%b exp 8/0000", disp_cnt, out_valid); end
   endtask

   task automatic test_drop();
      chan_en = 4'b0111; in_dest = 2'd3; in_data = 8'hEE; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL drop_out_valid got %b exp 0000", out_valid); end
      checks++; if (disp_cnt !== 16'd8) begin errors++; $display("FAIL drop_disp got %0d exp 8", disp_cnt); end
      chan_en = 4'hF;
   endtask

   task automatic test_reset_full();
      out_ready = 4'b0000; in_valid = 1'b1; in_dest = 2'd0; in_data = 8'h99;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL rf_full got %b exp 0001", out_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rf_out_valid got %b exp 0000", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready got %b exp 1", in_ready); end
      checks++; if (drop_cnt !== 16'd0 || disp_cnt !== 16'd0 || out_data !== 8'h00) begin errors++; $display("FAIL rf_regs got %0d/%0d/%h exp 0/0/00", drop_cnt, disp_cnt, out_data); end
      out_ready = 4'hF;
      tick();
      checks++; if (disp_cnt !== 16'd0) begin errors++; $display("FAIL rf_discard got %0d exp 0", disp_cnt); end
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_rr();
      test_back_to_back();
      test_drop();
      test_reset_full();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
